// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its key FIFO.
package keypad_pkg;

  // Scanner states: column sweep, press qualification, key held, release qualification.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // Linear key number as seen by software: row-major over the column count.
  function automatic int key_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for debounced key codes, with a registered head
// entry and a sticky overflow flag for presses dropped while full.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     overflow_clr,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             overflow_q, overflow_d;
  logic             full, do_pop, do_push, drop;

  // Next-state: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    full       = (count_q == FULL);
    do_pop     = pop && (count_q != '0);
    do_push    = push && (!full || do_pop);
    drop       = push && full && !do_pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_d     = mem_d[rd_ptr_d];
    // A drop in the same cycle as a clear wins so the event is never lost.
    overflow_d = drop | (overflow_q & ~overflow_clr);
  end

  // Storage, pointers, count and flags.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  assign head     = head_q;
  assign valid    = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: sweeps one-cold columns, debounces a single-key
// press and release, and queues each accepted key code into a FIFO.
//
// state        | meaning
// ST_SCAN      | sweeping columns, rows sampled in the last dwell cycle
// ST_DEBOUNCE  | column frozen, counting samples with only the latched row low
// ST_HELD      | key accepted and queued, waiting for the latched row to rise
// ST_RELEASE   | counting all-rows-high samples before resuming the sweep
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 8,
  parameter int DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            nRST,
  input  logic [ROWS-1:0]                 RowIn,
  output logic [COLS-1:0]                 ColOut,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_valid,
  input  logic                            key_read,
  output logic [$clog2(DEPTH):0]          fifo_count,
  output logic                            overflow,
  input  logic                            overflow_clr
);

  localparam int KW = $clog2(ROWS * COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(DWELL);
  localparam int BW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  logic [ROWS-1:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  scan_state_e     state_q, state_d;
  logic [CW-1:0]   col_q, col_d, col_next;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d, low_idx;
  logic [COLS-1:0] col_out_q, col_out_d;
  logic [ROWS-1:0] lows, row_mask;
  logic            one_low, row_hit, push;
  logic [KW-1:0]   push_code;

  // Two-flop synchroniser for the asynchronous row inputs.
  always_comb begin
    row_s1_d = RowIn;
    row_s2_d = row_s1_q;
  end

  // Synchroniser flops idle high (no key pressed).
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= row_s1_d;
      row_s2_q <= row_s2_d;
    end
  end

  // Scan/debounce next-state; push fires in the cycle the press is accepted.
  always_comb begin
    lows      = ~row_s2_q;
    one_low   = $onehot(lows);
    low_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (lows[i]) low_idx = RW'(i);
    end
    row_mask  = ROWS'(1) << row_q;
    row_hit   = |(lows & row_mask);
    col_next  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    push_code = KW'(key_index(int'(row_q), int'(col_q), COLS));
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    push      = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            state_d = ST_DEBOUNCE;
            row_d   = low_idx;
            cnt_d   = '0;
          end else begin
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (lows == row_mask) begin
          if (cnt_q == DEB_LAST) begin
            push    = 1'b1;
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_SCAN;
          dwell_d = '0;
          cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!row_hit) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (lows == '0) begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_SCAN;
            col_d   = col_next;
            dwell_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (row_hit) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
    col_out_d = ~(COLS'(1) << col_d);
  end

  // Scanner state and registered column drive.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_SCAN;
      col_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_out_q <= ~COLS'(1);
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_out_q <= col_out_d;
    end
  end

  assign ColOut = col_out_q;

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KW)
  ) u_fifo (
    .clk          (clk),
    .nRST         (nRST),
    .push         (push),
    .push_data    (push_code),
    .pop          (key_read),
    .overflow_clr (overflow_clr),
    .head         (key_code),
    .valid        (key_valid),
    .count        (fifo_count),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with default parameters. A keypad
// model pulls a row low while a pressed key's column is driven.
module tb_keypad_scan_fifo;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_read;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .DWELL(4), .DEBOUNCE(8), .DEPTH(4)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .RowIn        (RowIn),
    .ColOut       (ColOut),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_read     (key_read),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Keypad matrix: key k sits at row k/4, column k%4.
  always_comb begin
    RowIn = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (keys[k] && !ColOut[k % 4]) RowIn[k / 4] = 1'b0;
    end
  end

  // Wait for a fresh start of column c (returns at the negedge of its first cycle).
  task automatic wait_col(input int c, output bit ok);
    logic [3:0] target;
    logic [3:0] prev;
    target = ~(4'b0001 << c);
    prev   = ColOut;
    ok     = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ColOut == target && prev != target) ok = 1'b1;
      prev = ColOut;
    end
  endtask

  // Press aligned to a column start; returns at the negedge of the push cycle.
  task automatic press_aligned(input int k, output bit ok);
    wait_col(k % 4, ok);
    keys[k] = 1'b1;
    repeat (11) @(negedge clk);
  endtask

  task automatic press_key(input int k);
    keys[k] = 1'b1;
    repeat (40) @(negedge clk);
    keys[k] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic release_key(input int k);
    keys[k] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_one();
    key_read = 1'b1;
    @(negedge clk);
    key_read = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; keys = '0; key_read = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ColOut !== 4'b1110) begin errors++; $display("FAIL reset_colout: got %b want 1110", ColOut); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ColOut !== 4'b1110) begin errors++; $display("FAIL dwell_col0: got %b want 1110", ColOut); end
    @(negedge clk);
    checks++; if (ColOut !== 4'b1101) begin errors++; $display("FAIL dwell_col1: got %b want 1101", ColOut); end
  endtask

  task automatic test_single_press();
    bit ok;
    press_aligned(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_wait: column 3 never started"); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_early: got %0d want 0", fifo_count); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL single_code: got %0d want 3", key_code); end
    repeat (28) @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_hold: got %0d want 1", fifo_count); end
    keys[3] = 1'b0;
    for (int i = 0; i < 40 && ColOut == 4'b0111; i++) @(negedge clk);
    checks++; if (ColOut !== 4'b1110) begin errors++; $display("FAIL single_resume: got %b want 1110", ColOut); end
    checks++; if (fifo_count !== 3'd1 || key_code !== 4'd3) begin errors++; $display("FAIL single_after: count %0d code %0d want 1/3", fifo_count, key_code); end
    pop_one();
    checks++; if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL single_pop: valid %b count %0d want 0/0", key_valid, fifo_count); end
  endtask

  task automatic test_bounce();
    bit ok;
    wait_col(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_wait: column 0 never started"); end
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      keys[8] = (cyc == 1 || cyc == 6 || cyc == 11 || cyc >= 13);
      if (cyc == 26) begin
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL bounce_early: got %0d want 0", fifo_count); end
      end
      if (cyc == 27) begin
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL bounce_push: got %0d want 1", fifo_count); end
      end
    end
    release_key(8);
    checks++; if (fifo_count !== 3'd1 || key_code !== 4'd8) begin errors++; $display("FAIL bounce_entry: count %0d code %0d want 1/8", fifo_count, key_code); end
    pop_one();
  endtask

  task automatic test_overflow();
    int seq[5] = '{15, 2, 11, 12, 4};
    int exp_q[4] = '{15, 2, 11, 12};
    bit ok;
    for (int i = 0; i < 5; i++) begin
      press_key(seq[i]);
      if (i < 4) begin
        checks++; if (fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL ovf_fill%0d: got %0d want %0d", i, fifo_count, i + 1); end
      end else begin
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: count %0d ovf %b want 4/1", fifo_count, overflow); end
      end
    end
    overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    press_aligned(1, ok);
    overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
    checks++; if (!ok || overflow !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_clr_race: ok %b ovf %b count %0d want 1/1/4", ok, overflow, fifo_count); end
    release_key(1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(exp_q[i])) begin errors++; $display("FAIL ovf_pop%0d: valid %b code %0d want 1/%0d", i, key_valid, key_code, exp_q[i]); end
      pop_one();
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", key_valid); end
    pop_one();
    checks++; if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin errors++; $display("FAIL empty_read: count %0d valid %b want 0/0", fifo_count, key_valid); end
    overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
  endtask

  task automatic test_ghost();
    bit wrapped = 1'b0;
    logic [3:0] prev;
    keys[5] = 1'b1; keys[9] = 1'b1;
    prev = ColOut;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && ColOut == 4'b1110) wrapped = 1'b1;
      prev = ColOut;
    end
    checks++; if (!wrapped) begin errors++; $display("FAIL ghost_wrap: no 3->0 wrap seen"); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ghost_push: got %0d want 0", fifo_count); end
    keys[5] = 1'b0; keys[9] = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int exp_q[4] = '{6, 7, 13, 14};
    bit ok;
    press_key(1); press_key(6); press_key(7); press_key(13);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_fill: got %0d want 4", fifo_count); end
    press_aligned(14, ok);
    key_read = 1'b1; @(negedge clk); key_read = 1'b0;
    checks++; if (!ok || fifo_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_same: ok %b count %0d ovf %b want 1/4/0", ok, fifo_count, overflow); end
    release_key(14);
    for (int i = 0; i < 4; i++) begin
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(exp_q[i])) begin errors++; $display("FAIL b2b_pop%0d: valid %b code %0d want 1/%0d", i, key_valid, key_code, exp_q[i]); end
      pop_one();
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", key_valid); end
  endtask

  task automatic test_reset_held();
    bit ok;
    press_aligned(5, ok);
    @(negedge clk);
    checks++; if (!ok || fifo_count !== 3'd1) begin errors++; $display("FAIL rh_first: ok %b count %0d want 1/1", ok, fifo_count); end
    repeat (3) @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);
    checks++; if (ColOut !== 4'b1110 || fifo_count !== 3'd0 || key_valid !== 1'b0) begin errors++; $display("FAIL rh_reset: col %b count %0d valid %b want 1110/0/0", ColOut, fifo_count, key_valid); end
    nRST = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rh_early: got %0d want 0", fifo_count); end
    for (int i = 0; i < 60 && !key_valid; i++) @(negedge clk);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin errors++; $display("FAIL rh_repush: valid %b code %0d want 1/5", key_valid, key_code); end
    repeat (30) @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rh_once: got %0d want 1", fifo_count); end
    release_key(5);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow();
    test_ghost();
    test_back_to_back();
    test_reset_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
